// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter granting two requesters access to a shared
//               4-bit combinational ALU, with a single-entry response port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic [DW-1:0] r0_a,
    input  logic [DW-1:0] r0_b,
    input  logic [3:0]    r0_sel,
    input  logic          r0_cin,
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic [DW-1:0] r1_a,
    input  logic [DW-1:0] r1_b,
    input  logic [3:0]    r1_sel,
    input  logic          r1_cin,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_sel,
    output logic          alu_cin,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_cout,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_cout,
    output logic          rsp_err,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last_grant;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    logic [3:0]    r_op_sel;
    logic          r_op_cin;
    logic          r_rsp_id;
    logic [DW-1:0] r_rsp_data;
    logic          r_rsp_cout;
    logic          r_rsp_err;

    logic          w_grant_id;
    logic          w_accept;
    logic          w_illegal;
    logic [DW-1:0] w_in_a;
    logic [DW-1:0] w_in_b;
    logic [3:0]    w_in_sel;
    logic          w_in_cin;

    // A tie goes to the requester that was not served last.
    always_comb begin
        w_grant_id = (r0_valid & r1_valid) ? ~r_last_grant : r1_valid;
        w_accept   = (r_state == ST_IDLE) & (r0_valid | r1_valid);
        r0_ready   = w_accept & ~w_grant_id;
        r1_ready   = w_accept &  w_grant_id;
        w_in_a     = w_grant_id ? r1_a   : r0_a;
        w_in_b     = w_grant_id ? r1_b   : r0_b;
        w_in_sel   = w_grant_id ? r1_sel : r0_sel;
        w_in_cin   = w_grant_id ? r1_cin : r0_cin;
        // Unassigned opcodes x11x, and divide by zero.
        w_illegal  = (w_in_sel[2:1] == 2'b11) ||
                     ((w_in_sel == 4'b0011) && (w_in_b == '0));
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = w_illegal ? ST_RESP : ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_sel     <= '0;
            r_op_cin     <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_cout   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_grant_id;
            r_op_a       <= w_in_a;
            r_op_b       <= w_in_b;
            r_op_sel     <= w_in_sel;
            r_op_cin     <= w_in_cin;
            r_rsp_id     <= w_grant_id;
            if (w_illegal) begin
                r_rsp_data <= '0;
                r_rsp_cout <= 1'b0;
                r_rsp_err  <= 1'b1;
            end
        end else if (r_state == ST_EXEC) begin
            // Carry-out is only meaningful for add and subtract.
            r_rsp_data <= alu_out;
            r_rsp_cout <= (r_op_sel[3:1] == 3'b000) & alu_cout;
            r_rsp_err  <= 1'b0;
        end
    end

    assign alu_a     = r_op_a;
    assign alu_b     = r_op_b;
    assign alu_sel   = r_op_sel;
    assign alu_cin   = r_op_cin;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Scoreboard bench for alu_arbiter with an attached ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int DW = 4;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sel;
        logic       cin;
    } op_t;

    typedef struct packed {
        op_t        op;
        logic       id;
        logic [3:0] data;
        logic       cout;
        logic       err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_valid, r0_ready, r0_cin;
    logic          r1_valid, r1_ready, r1_cin;
    logic [DW-1:0] r0_a, r0_b, r1_a, r1_b;
    logic [3:0]    r0_sel, r1_sel;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic [3:0]    alu_sel;
    logic          alu_cin, alu_cout;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_err, busy;
    logic [DW-1:0] rsp_data;

    always #5 clk = ~clk;

    alu_arbiter #(.DW(DW)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_sel(r0_sel), .r0_cin(r0_cin),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_sel(r1_sel), .r1_cin(r1_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
        .busy(busy)
    );

    // Shared ALU; bit 4 is carry/borrow for add/sub and junk otherwise.
    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] sel, input logic cin);
        logic [4:0] r;
        case (sel)
            4'd0:    r = {1'b0, a} + {1'b0, b} + {4'b0, cin};
            4'd1:    r = {1'b0, a} - {1'b0, b} - {4'b0, cin};
            4'd2:    r = {^a, a * b};
            4'd3:    r = (b == 4'd0) ? 5'd0 : {^a, a / b};
            4'd4:    r = {^a, a << 1};
            4'd5:    r = {^a, a >> 1};
            4'd8:    r = {^a, a & b};
            4'd9:    r = {^a, a | b};
            4'd10:   r = {^a, a ^ b};
            4'd11:   r = {^a, ~a};
            4'd12:   r = {^a, ~(a & b)};
            4'd13:   r = {^a, ~(a | b)};
            default: r = {^a, 4'd0};
        endcase
        return r;
    endfunction

    always_comb {alu_cout, alu_out} = alu_f(alu_a, alu_b, alu_sel, alu_cin);

    function automatic exp_t ref_resp(input op_t o, input logic id);
        exp_t       e;
        logic [4:0] r;
        e.op = o;
        e.id = id;
        if ((o.sel inside {4'd6, 4'd7, 4'd14, 4'd15}) || (o.sel == 4'd3 && o.b == 4'd0)) begin
            e.data = 4'd0; e.cout = 1'b0; e.err = 1'b1;
        end else begin
            r      = alu_f(o.a, o.b, o.sel, o.cin);
            e.data = r[3:0];
            e.cout = (o.sel < 4'd2) ? r[4] : 1'b0;
            e.err  = 1'b0;
        end
        return e;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb[$];
    bit   acc0 = 0, acc1 = 0;
    bit   gaps = 0;
    int   rr_mode = 1;

    // Requester 0: hold each op until accepted.
    initial begin
        op_t o;
        r0_valid = 0; r0_a = 0; r0_b = 0; r0_sel = 0; r0_cin = 0;
        forever begin
            @(posedge clk); #1;
            if (acc0) begin r0_valid = 0; acc0 = 0; end
            if (!r0_valid && q0.size() > 0 && !(gaps && $urandom_range(0, 2) == 0)) begin
                o = q0.pop_front();
                {r0_a, r0_b, r0_sel, r0_cin} = o;
                r0_valid = 1;
            end
        end
    end

    // Requester 1
    initial begin
        op_t o;
        r1_valid = 0; r1_a = 0; r1_b = 0; r1_sel = 0; r1_cin = 0;
        forever begin
            @(posedge clk); #1;
            if (acc1) begin r1_valid = 0; acc1 = 0; end
            if (!r1_valid && q1.size() > 0 && !(gaps && $urandom_range(0, 2) == 0)) begin
                o = q1.pop_front();
                {r1_a, r1_b, r1_sel, r1_cin} = o;
                r1_valid = 1;
            end
        end
    end

    initial begin
        rsp_ready = 0;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0:       rsp_ready = ($urandom_range(0, 2) != 0);
                1:       rsp_ready = 1;
                default: rsp_ready = 0;
            endcase
        end
    end

    // Reference: one op in flight; legal ops respond two cycles after the
    // grant cycle, illegal ones one cycle after; ties go to the other side.
    bit m_busy = 0;
    bit m_last = 1;
    int m_lat  = 0;

    initial begin
        logic [1:0] erdy;
        logic       gid;
        exp_t       e;
        op_t        o;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete(); m_busy = 0; m_last = 1; m_lat = 0;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("rst_alu", 32'({alu_a, alu_b, alu_sel, alu_cin}), 32'd0);
                chk("rst_rsp", 32'({rsp_id, rsp_data, rsp_cout, rsp_err}), 32'd0);
            end else begin
                erdy = 2'b00;
                gid  = 1'b0;
                if (!m_busy && (r0_valid || r1_valid)) begin
                    gid  = (r0_valid && r1_valid) ? !m_last : r1_valid;
                    erdy = gid ? 2'b10 : 2'b01;
                end
                chk("ready", 32'({r1_ready, r0_ready}), 32'(erdy));
                chk("busy", 32'(busy), 32'(m_busy));
                chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_lat == 0));
                if (m_busy && sb.size() > 0) begin
                    e = sb[0];
                    if (m_lat > 0) begin
                        chk("alu_in", 32'({alu_a, alu_b, alu_sel, alu_cin}), 32'(e.op));
                        m_lat--;
                    end else begin
                        chk("rsp_fields", 32'({rsp_id, rsp_data, rsp_cout, rsp_err}),
                            32'({e.id, e.data, e.cout, e.err}));
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            m_busy = 0;
                        end
                    end
                end
                if (erdy != 2'b00) begin
                    o = gid ? {r1_a, r1_b, r1_sel, r1_cin} : {r0_a, r0_b, r0_sel, r0_cin};
                    e = ref_resp(o, gid);
                    sb.push_back(e);
                    m_busy = 1;
                    m_last = gid;
                    m_lat  = e.err ? 0 : 1;
                    if (gid) acc1 = 1; else acc0 = 1;
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || r0_valid || r1_valid || m_busy) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL idle_timeout actual=busy required=idle at %0t", $time);
        end
    endtask

    initial begin
        int n;
        op_t o;
        repeat (3) @(posedge clk);
        #2 rst = 0;

        q0.push_back(op_t'{4'd5, 4'd3, 4'd0, 1'b1});
        wait_idle(50);

        repeat (2) begin
            q0.push_back(op_t'{4'hC, 4'hA, 4'd8, 1'b0});
            q1.push_back(op_t'{4'hC, 4'h3, 4'd9, 1'b0});
        end
        wait_idle(100);

        q1.push_back(op_t'{4'd7, 4'd0, 4'd3, 1'b0});
        q0.push_back(op_t'{4'd3, 4'd4, 4'd14, 1'b1});
        wait_idle(50);

        rr_mode = 2;
        q0.push_back(op_t'{4'd9, 4'd4, 4'd10, 1'b0});
        q1.push_back(op_t'{4'd1, 4'd2, 4'd0, 1'b0});
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL bp_wait actual=0 required=rsp_valid at %0t", $time);
        end
        repeat (5) @(negedge clk);
        rr_mode = 1;
        wait_idle(50);

        q0.push_back(op_t'{4'd2, 4'd5, 4'd1, 1'b0});
        n = 0;
        while (!(m_busy && m_lat == 1) && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL exec_wait actual=0 required=grant at %0t", $time);
        end
        @(posedge clk); #2 rst = 1;
        @(posedge clk); #2 rst = 0;
        repeat (4) @(negedge clk);

        q0.push_back(op_t'{4'd1, 4'd1, 4'd0, 1'b0});
        q1.push_back(op_t'{4'd2, 4'd2, 4'd0, 1'b0});
        wait_idle(50);

        q0.push_back(op_t'{4'd2, 4'd5, 4'd1, 1'b0});
        wait_idle(50);

        rr_mode = 0;
        gaps    = 1;
        for (int i = 0; i < 40; i++) begin
            o.a   = 4'($urandom);
            o.b   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            o.sel = 4'($urandom);
            o.cin = 1'($urandom);
            if (i % 2 == 0) q0.push_back(o); else q1.push_back(o);
        end
        wait_idle(3000);
        rr_mode = 1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
